i2c_expander_arb: RTL and testbench
===================================

Name: i2c_expander_arb

Overview:
- Round-robin arbiter and sequencer that shares one i2c_expander_mm bridge between N_REQ register-access requesters, for example the SFP status poller, the TX_DISABLE driver and the CPU.
- Latches one requester's transaction and drives the bridge rd_rq/wr_rq handshake.
- Captures read data, returns completion to the owner, then inserts the mandatory request-release cycle before the next grant.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- ADR_W, 4, bridge register address width.
- DATA_W, 32, bridge data width.
- TIMEOUT_CYCLES, 64, ISSUE-state watchdog limit (used only with I2C_ARB_TIMEOUT_EN).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  N_REQ  per-requester transaction request; held until req_done.
- req_write  in  N_REQ  1 = write, 0 = read.
- req_adr  in  N_REQ*ADR_W  packed register addresses, requester i at bits [i*ADR_W +: ADR_W].
- req_wdata  in  N_REQ*DATA_W  packed write data.
- req_done  out  N_REQ  one-cycle completion pulse to the owner.
- req_err  out  N_REQ  one-cycle timeout pulse, coincident with req_done.
- rsp_rdata  out  DATA_W  last captured read data; valid with req_done of a read.
- busy  out  1  high when state != IDLE.
- rd_rq  out  1  bridge read request.
- wr_rq  out  1  bridge write request.
- rd_adr  out  ADR_W  bridge read address.
- wr_adr  out  ADR_W  bridge write address.
- wr_data  out  DATA_W  bridge write data.
- rd_data  in  DATA_W  bridge read data; valid only while action_done is high.
- action_done  in  1  bridge completion strobe.

Behaviour:
- All outputs are registered.
- Reset values: every output is 0; rr pointer = N_REQ-1, so requester 0 is first in priority; state = IDLE.
- State machine states: IDLE, ISSUE, RELEASE.
- IDLE:
  - If any req_valid is high, grant the first requester at or after (pointer+1) mod N_REQ.
  - Latch its write flag, address and data, set the pointer to the grantee, go to ISSUE.
  - If no req_valid is high, stay in IDLE.
- ISSUE:
  - wr_rq = latched write; rd_rq = !latched write; never both high.
  - rd_adr and wr_adr both carry the latched address; wr_data carries the latched data.
  - All three are stable for the whole ISSUE state.
  - On action_done: capture rd_data into rsp_rdata (reads only; writes leave rsp_rdata unchanged), go to RELEASE.
- RELEASE:
  - Exactly one cycle with rd_rq = wr_rq = 0, so the bridge leaves WAIT_RESET_RQ.
  - req_done[grantee] = 1 this cycle.
  - Next state is IDLE.
- Latency from req_valid sampled in IDLE at cycle t:
  - Write: wr_rq at t+1, action_done at t+2, req_done at t+3.
  - Read: rd_rq at t+1, action_done at t+4, req_done at t+5.
  - Back-to-back throughput: one write per 4 cycles, one read per 6 cycles.
- Requester rule:
  - req_valid still high in the cycle after req_done is a new transaction.
  - Requesters drop req_valid on the edge after req_done.
  - req_valid changes from non-granted requesters are ignored until the next IDLE.
- action_done in IDLE or RELEASE is ignored; no state change, no capture.
- Fairness: after a grant, that requester has lowest priority next IDLE. With all N_REQ requesting continuously, grants rotate 0,1,2,3,0…
- Reset mid-transaction: rq is dropped immediately and no req_done is produced; requesters must reissue.

Optional Feature:
- Macro: I2C_ARB_TIMEOUT_EN.
- With it defined:
  - A counter runs in ISSUE.
  - If TIMEOUT_CYCLES cycles elapse without action_done, go to RELEASE with req_done and req_err pulsed for the grantee; rsp_rdata is unchanged.
  - If action_done arrives in the same cycle as expiry, action_done wins and req_err = 0.
  - The counter clears on leaving ISSUE.
- Without it: ISSUE waits indefinitely, req_err is tied to 0, and no counter is built.

Decomposition:
- Package i2c_expander_pkg holds:
  - typedef enum arb_state_t {IDLE, ISSUE, RELEASE};
  - constants EXP_ADR_W = 4 and EXP_DATA_W = 32 (shared with i2c_expander_mm);
  - expander register address constants.
- Sub-module rr_pick: combinational, parameterised N; inputs are the request vector and pointer; outputs are a one-hot grant and the grant index. Reusable elsewhere.

Test Plan:
- Single write, req 1, adr 4'h3, data 32'h0000_00A5, with bridge model → wr_rq high t+1..t+2, wr_adr = 3, wr_data = A5, req_done[1] at t+3, rd_rq never high.
- Single read, req 2, adr 4'h1, bridge returns 32'h0000_005C on action_done → rd_rq t+1..t+4, rsp_rdata = 5C with req_done[2] at t+5.
- All four requesters hold req_valid, mixed read/write → grant order 0,1,2,3,0; at least one rq-low cycle between consecutive transactions; never wr_rq & rd_rq.
- Requester 0 re-requests immediately after its done while requester 3 waits → requester 3 granted next.
- reset asserted in the cycle after wr_rq rises → all outputs 0 asynchronously; after release, an idle bus stays IDLE with busy = 0 and no spurious req_done.
- With I2C_ARB_TIMEOUT_EN and TIMEOUT_CYCLES = 8, bridge never asserts action_done → req_done and req_err pulse together 9 cycles after grant, then the next requester is served. Second run: action_done exactly on the expiry cycle → req_err = 0.

Source files
------------

// File: rtl/i2c_expander_pkg.sv
// i2c_expander_pkg
//   Shared types and constants for the i2c_expander bridge family.
//   - arb_state_t : sequencer states of i2c_expander_arb
//   - EXP_ADR_W / EXP_DATA_W : bridge register address / data widths,
//     shared with i2c_expander_mm
//   - EXP_REG_* : expander register map
package i2c_expander_pkg;

    localparam int EXP_ADR_W  = 4;
    localparam int EXP_DATA_W = 32;

    // Expander register map (bridge address space)
    localparam logic [EXP_ADR_W-1:0] EXP_REG_INPUT    = 4'h0;
    localparam logic [EXP_ADR_W-1:0] EXP_REG_OUTPUT   = 4'h1;
    localparam logic [EXP_ADR_W-1:0] EXP_REG_POLARITY = 4'h2;
    localparam logic [EXP_ADR_W-1:0] EXP_REG_CONFIG   = 4'h3;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        RELEASE = 2'd2
    } arb_state_t;

endpackage

// File: rtl/i2c_expander_arb_rr_pick.sv
// rr_pick
//   Combinational round-robin picker. Grants the first set request bit at
//   or after (ptr_i + 1) mod N, so the last grantee has lowest priority.
//   Ports:
//     req_i  [N]  request vector
//     ptr_i  [IW] index of the previous grantee
//     gnt_o  [N]  one-hot grant (all zero when no request)
//     idx_o  [IW] index of the granted bit (0 when no request)
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  gnt_o,
    output logic [IW-1:0] idx_o
);

    always_comb begin
        int  j;
        logic found;
        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        j     = 0;
        // k = N wraps back onto the previous grantee itself
        for (int k = 1; k <= N; k++) begin
            j = (int'(ptr_i) + k) % N;
            if (!found && req_i[j]) begin
                found    = 1'b1;
                gnt_o[j] = 1'b1;
                idx_o    = IW'(j);
            end
        end
    end

endmodule

// File: rtl/i2c_expander_arb.sv
// i2c_expander_arb
//   Round-robin arbiter/sequencer sharing one i2c_expander_mm bridge between
//   N_REQ register-access requesters. Latches the grantee's transaction,
//   holds rd_rq/wr_rq until action_done, captures read data, then spends one
//   RELEASE cycle with both requests low (the bridge needs it to leave
//   WAIT_RESET_RQ) while pulsing req_done to the owner.
//   Ports:
//     clk, reset            clock, async active-high reset
//     req_valid/write [N]   per-requester request and direction
//     req_adr   [N*ADR_W]   packed addresses, requester i at [i*ADR_W +: ADR_W]
//     req_wdata [N*DATA_W]  packed write data
//     req_done/req_err [N]  one-cycle completion / timeout pulse
//     rsp_rdata             last captured read data
//     busy                  state != IDLE
//     rd_rq/wr_rq, rd_adr/wr_adr, wr_data, rd_data, action_done : bridge side
//   Optional: define I2C_ARB_TIMEOUT_EN to build the ISSUE watchdog
//   (TIMEOUT_CYCLES); otherwise ISSUE waits forever and req_err is 0.
//   All outputs are registered.
module i2c_expander_arb
    import i2c_expander_pkg::*;
#(
    parameter int N_REQ          = 4,
    parameter int ADR_W          = EXP_ADR_W,
    parameter int DATA_W         = EXP_DATA_W,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [N_REQ-1:0]          req_valid,
    input  logic [N_REQ-1:0]          req_write,
    input  logic [N_REQ*ADR_W-1:0]    req_adr,
    input  logic [N_REQ*DATA_W-1:0]   req_wdata,
    output logic [N_REQ-1:0]          req_done,
    output logic [N_REQ-1:0]          req_err,
    output logic [DATA_W-1:0]         rsp_rdata,
    output logic                      busy,
    output logic                      rd_rq,
    output logic                      wr_rq,
    output logic [ADR_W-1:0]          rd_adr,
    output logic [ADR_W-1:0]          wr_adr,
    output logic [DATA_W-1:0]         wr_data,
    input  logic [DATA_W-1:0]         rd_data,
    input  logic                      action_done
);

    localparam int IW = $clog2(N_REQ);

    if (N_REQ < 2 || N_REQ > 8) begin : g_bad_nreq
        $error("i2c_expander_arb: N_REQ must be 2..8");
    end
    if (TIMEOUT_CYCLES < 2) begin : g_bad_tmo
        $error("i2c_expander_arb: TIMEOUT_CYCLES must be >= 2");
    end

    arb_state_t         state_q, state_d;
    logic [IW-1:0]      ptr_q, ptr_d;
    logic [N_REQ-1:0]   own_q, own_d;
    logic               lwr_q, lwr_d;
    logic [ADR_W-1:0]   adr_q, adr_d;
    logic [DATA_W-1:0]  wdat_q, wdat_d;
    logic [DATA_W-1:0]  rdat_q, rdat_d;
    logic [N_REQ-1:0]   done_q, done_d;
    logic               busy_q, wr_rq_q, rd_rq_q;

    logic [N_REQ-1:0]   pick_gnt;
    logic [IW-1:0]      pick_idx;

    rr_pick #(.N(N_REQ), .IW(IW)) u_pick (
        .req_i (req_valid),
        .ptr_i (ptr_q),
        .gnt_o (pick_gnt),
        .idx_o (pick_idx)
    );

`ifdef I2C_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0]      tmo_q;
    logic [N_REQ-1:0]   err_q;
    logic               tmo_hit;

    // Fires on the TIMEOUT_CYCLES-th ISSUE cycle
    assign tmo_hit = (state_q == ISSUE) && (tmo_q == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tmo_q <= '0;
            err_q <= '0;
        end else begin
            tmo_q <= (state_q == ISSUE && state_d == ISSUE) ? tmo_q + 1'b1 : '0;
            // action_done on the expiry cycle wins: no error
            err_q <= (tmo_hit && !action_done) ? own_q : '0;
        end
    end
    assign req_err = err_q;
`else
    assign req_err = '0;
`endif

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        own_d   = own_q;
        lwr_d   = lwr_q;
        adr_d   = adr_q;
        wdat_d  = wdat_q;
        rdat_d  = rdat_q;
        done_d  = '0;
        case (state_q)
            IDLE: begin
                if (|req_valid) begin
                    state_d = ISSUE;
                    ptr_d   = pick_idx;
                    own_d   = pick_gnt;
                    lwr_d   = req_write[pick_idx];
                    adr_d   = req_adr[int'(pick_idx)*ADR_W +: ADR_W];
                    wdat_d  = req_wdata[int'(pick_idx)*DATA_W +: DATA_W];
                end
            end
            ISSUE: begin
                if (action_done) begin
                    state_d = RELEASE;
                    done_d  = own_q;
                    if (!lwr_q) rdat_d = rd_data;
                end
`ifdef I2C_ARB_TIMEOUT_EN
                else if (tmo_hit) begin
                    state_d = RELEASE;
                    done_d  = own_q;
                end
`endif
            end
            RELEASE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            ptr_q   <= IW'(N_REQ - 1);
            own_q   <= '0;
            lwr_q   <= 1'b0;
            adr_q   <= '0;
            wdat_q  <= '0;
            rdat_q  <= '0;
            done_q  <= '0;
            busy_q  <= 1'b0;
            wr_rq_q <= 1'b0;
            rd_rq_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            own_q   <= own_d;
            lwr_q   <= lwr_d;
            adr_q   <= adr_d;
            wdat_q  <= wdat_d;
            rdat_q  <= rdat_d;
            done_q  <= done_d;
            busy_q  <= (state_d != IDLE);
            // Requests are decoded from the next state so they are high for
            // exactly the ISSUE cycles and mutually exclusive.
            wr_rq_q <= (state_d == ISSUE) &&  lwr_d;
            rd_rq_q <= (state_d == ISSUE) && !lwr_d;
        end
    end

    assign req_done  = done_q;
    assign rsp_rdata = rdat_q;
    assign busy      = busy_q;
    assign wr_rq     = wr_rq_q;
    assign rd_rq     = rd_rq_q;
    assign rd_adr    = adr_q;
    assign wr_adr    = adr_q;
    assign wr_data   = wdat_q;

endmodule

// File: tb/tb_i2c_expander_arb.sv
// Directed bench for i2c_expander_arb (N_REQ=4, TIMEOUT_CYCLES=8).
// A small bridge model answers writes one cycle after wr_rq rises and reads
// three cycles after rd_rq rises. Timeout scenarios build only with
// I2C_ARB_TIMEOUT_EN.
module tb_i2c_expander_arb;
    localparam int N  = 4;
    localparam int AW = 4;
    localparam int DW = 32;

    logic              clk = 1'b0;
    logic              reset;
    logic [N-1:0]      req_valid, req_write;
    logic [N*AW-1:0]   req_adr;
    logic [N*DW-1:0]   req_wdata;
    logic [N-1:0]      req_done, req_err;
    logic [DW-1:0]     rsp_rdata, wr_data, rd_data;
    logic              busy, rd_rq, wr_rq, action_done;
    logic [AW-1:0]     rd_adr, wr_adr;

    // bridge model
    logic              bridge_en = 1'b1;
    logic              echo      = 1'b0;
    logic              auto_done = 1'b0;
    logic              man_done  = 1'b0;
    logic [DW-1:0]     bridge_rdata = '0;
    int                rq_cnt = 0;

    int total = 0;
    int bad   = 0;

    i2c_expander_arb #(
        .N_REQ(N), .ADR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(8)
    ) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_write(req_write),
        .req_adr(req_adr), .req_wdata(req_wdata),
        .req_done(req_done), .req_err(req_err), .rsp_rdata(rsp_rdata),
        .busy(busy), .rd_rq(rd_rq), .wr_rq(wr_rq),
        .rd_adr(rd_adr), .wr_adr(wr_adr), .wr_data(wr_data),
        .rd_data(rd_data), .action_done(action_done)
    );

    always #5 clk = ~clk;

    assign action_done = auto_done | man_done;
    assign rd_data     = echo ? (32'hC0DE_0000 | 32'(rd_adr)) : bridge_rdata;

    always @(negedge clk) begin
        if (wr_rq || rd_rq) rq_cnt = rq_cnt + 1;
        else                rq_cnt = 0;
        auto_done = bridge_en && ((wr_rq && rq_cnt == 2) || (rd_rq && rq_cnt == 4));
    end

    initial begin
        #200000;
        $display("FAIL global_watchdog observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic wait_done(input string tag, input int budget, output logic [N-1:0] d);
        d = '0;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (req_done != '0) begin
                d = req_done;
                return;
            end
        end
        total++;
        bad++;
        $error("FAIL %s observed=no_done expected=done_within_%0d", tag, budget);
    endtask

    function automatic logic [127:0] all_out();
        return {req_done, req_err, rsp_rdata, busy, rd_rq, wr_rq, rd_adr, wr_adr, wr_data};
    endfunction

    initial begin
        logic [N-1:0]  d;
        int            ord [5];
        int            n, both, gapbad, spur;
        logic [DW-1:0] exp_rsp;
        logic          rq_now;

        ord = '{0, 1, 2, 3, 0};
        reset = 1'b1; req_valid = '0; req_write = '0; req_adr = '0; req_wdata = '0;
        tick(); tick();
        chk("reset_outputs", all_out(), 128'd0);
        reset = 1'b0;
        tick();
        chk("post_reset_idle", all_out(), 128'd0);

        // ---- single write: req 1, adr 3, data A5
        req_valid = 4'b0010; req_write = 4'b0010;
        req_adr[1*AW +: AW] = 4'h3; req_wdata[1*DW +: DW] = 32'h0000_00A5;
        tick();                                    // t+1
        chk("wr_t1_wr_rq", wr_rq, 1'b1);
        chk("wr_t1_rd_rq", rd_rq, 1'b0);
        chk("wr_t1_adr",   wr_adr, 4'h3);
        chk("wr_t1_data",  wr_data, 32'hA5);
        chk("wr_t1_busy",  busy, 1'b1);
        tick();                                    // t+2
        chk("wr_t2_rq",    {wr_rq, rd_rq, req_done}, {2'b10, 4'b0000});
        tick();                                    // t+3
        chk("wr_t3_done",  {wr_rq, rd_rq, req_done, req_err}, {2'b00, 4'b0010, 4'b0000});
        req_valid = '0;
        tick();                                    // t+4
        chk("wr_t4_idle",  {busy, req_done}, 5'b0);

        // ---- single read: req 2, adr 1, bridge returns 5C
        bridge_rdata = 32'h0000_005C;
        req_valid = 4'b0100; req_write = 4'b0000;
        req_adr[2*AW +: AW] = 4'h1;
        tick();                                    // t+1
        chk("rd_t1_rq",  {rd_rq, wr_rq, rd_adr}, {2'b10, 4'h1});
        tick(); tick(); tick();                    // t+4
        chk("rd_t4_rq",  {rd_rq, req_done, rsp_rdata}, {1'b1, 4'b0000, 32'h0});
        tick();                                    // t+5
        chk("rd_t5_done", {rd_rq, req_done, rsp_rdata}, {1'b0, 4'b0100, 32'h5C});
        req_valid = '0;
        tick();

        // ---- action_done while IDLE must be ignored
        bridge_rdata = 32'h0000_00FF;
        man_done = 1'b1;
        tick();
        man_done = 1'b0;
        tick();
        chk("idle_done_ignored", {busy, req_done, rsp_rdata}, {1'b0, 4'b0000, 32'h5C});

        // ---- all four requesting, mixed r/w: order 0,1,2,3,0
        reset = 1'b1; tick(); reset = 1'b0;
        echo = 1'b1;
        req_write = 4'b0101;
        for (int i = 0; i < N; i++) req_adr[i*AW +: AW] = AW'(i + 4);
        req_valid = 4'b1111;
        n = 0; both = 0; gapbad = 0; exp_rsp = '0;
        for (int c = 0; c < 80 && n < 5; c++) begin
            tick();
            if (wr_rq && rd_rq) both++;
            rq_now = wr_rq | rd_rq;
            if (req_done != '0) begin
                if (rq_now) gapbad++;
                chk($sformatf("rr_grant%0d", n), req_done, 4'b0001 << ord[n]);
                if (!req_write[ord[n]]) exp_rsp = 32'hC0DE_0000 | 32'(ord[n] + 4);
                chk($sformatf("rr_rsp%0d", n), rsp_rdata, exp_rsp);
                n++;
                if (n == 5) req_valid = '0;
            end
        end
        chk("rr_count", n, 5);
        chk("rr_never_both", both, 0);
        chk("rr_release_gap", gapbad, 0);

        // ---- req 0 re-requests immediately; waiting req 3 must win
        tick();
        req_write = 4'b0001;
        req_adr[0*AW +: AW] = 4'hA; req_adr[3*AW +: AW] = 4'hB;
        req_valid = 4'b0001;
        tick();
        req_valid = 4'b1001;
        wait_done("fair_first", 20, d);
        chk("fair_first_owner", d, 4'b0001);
        tick();                                    // IDLE
        tick();
        chk("fair_second_issue", {rd_rq, wr_rq, rd_adr}, {2'b10, 4'hB});
        wait_done("fair_second", 20, d);
        chk("fair_second_owner", d, 4'b1000);
        req_valid = '0;
        tick();

        // ---- reset the cycle after wr_rq rises
        req_write = 4'b0010; req_valid = 4'b0010;
        tick();
        chk("rst_mid_wr_rq", wr_rq, 1'b1);
        tick();
        reset = 1'b1;
        #1;
        chk("rst_mid_async_zero", all_out(), 128'd0);
        req_valid = '0;
        tick();
        reset = 1'b0;
        spur = 0;
        for (int c = 0; c < 8; c++) begin
            tick();
            if (busy || rd_rq || wr_rq || req_done != '0) spur++;
        end
        chk("rst_mid_quiet", spur, 0);

`ifdef I2C_ARB_TIMEOUT_EN
        // ---- watchdog: bridge never answers the write from req 1
        bridge_en = 1'b0; echo = 1'b0; bridge_rdata = 32'h0000_0077;
        req_write = 4'b0010;
        req_adr[1*AW +: AW] = 4'h2; req_adr[2*AW +: AW] = 4'h6;
        req_valid = 4'b0110;                       // cycle t: grant req 1
        for (int c = 0; c < 8; c++) tick();        // t+8
        chk("tmo_t8_pending", {wr_rq, req_done}, {1'b1, 4'b0000});
        tick();                                    // t+9
        chk("tmo_t9_done_err", {req_done, req_err, rsp_rdata}, {4'b0010, 4'b0010, 32'h0});
        req_valid = 4'b0100;
        tick();                                    // IDLE, grant req 2
        chk("tmo_err_cleared", req_err, 4'b0000);
        tick();                                    // ISSUE cycle 1
        chk("tmo_next_served", {rd_rq, rd_adr}, {1'b1, 4'h6});
        for (int c = 0; c < 7; c++) tick();        // ISSUE cycle 8 = expiry
        man_done = 1'b1;
        tick();
        man_done = 1'b0;
        chk("tmo_tie_done", {req_done, req_err, rsp_rdata}, {4'b0100, 4'b0000, 32'h77});
        req_valid = '0;
        tick();
        bridge_en = 1'b1;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
